ps2_key_decoder: RTL

- Sits between `Ps2Interface` and the character-buffer writer in the VGA text path.
- Consumes raw PS/2 set-2 scancode bytes and tracks break (F0) and extended (E0) prefixes, shift and caps-lock state.
- Translates make codes to ASCII and queues characters in a small FIFO.
- Presents the queued characters on a valid/ready interface, which replaces the ad-hoc F0 flag and ASCII lookup RAM in the display top level.

---
 rtl/ps2_key_pkg.sv | 23 ++
 rtl/ps2_key_decoder_ascii_map.sv | 86 ++++++++
 rtl/ps2_key_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_pkg.sv
// Shared scancode constants and decoder state type for the PS/2 key decoder.
// Optional KEY_REPEAT_FILTER_EN behaviour lives in ps2_key_decoder.sv.
package ps2_key_pkg;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CAPS    = 8'h58;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] SC_SPACE   = 8'h29;

    localparam logic [7:0] ASCII_NONE = 8'h00;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_key_decoder_ascii_map.sv
// Combinational PS/2 set-2 make code to ASCII table (US layout).
// Returns ASCII_NONE for codes that produce no character.
module ps2_ascii_map
    import ps2_key_pkg::*;
(
    input  logic [7:0] scancode,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] plain;
    logic [7:0] shifted;

    // Letters carry their lowercase form; everything else carries both forms.
    always_comb begin
        letter  = ASCII_NONE;
        plain   = ASCII_NONE;
        shifted = ASCII_NONE;
        case (scancode)
            8'h1C: letter = 8'h61;
            8'h32: letter = 8'h62;
            8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;
            8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;
            8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;
            8'h42: letter = 8'h6B;
            8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;
            8'h31: letter = 8'h6E;
            8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;
            8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;
            8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;
            8'h1D: letter = 8'h77;
            8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;
            8'h1A: letter = 8'h7A;
            8'h45: begin plain = 8'h30; shifted = 8'h29; end
            8'h16: begin plain = 8'h31; shifted = 8'h21; end
            8'h1E: begin plain = 8'h32; shifted = 8'h40; end
            8'h26: begin plain = 8'h33; shifted = 8'h23; end
            8'h25: begin plain = 8'h34; shifted = 8'h24; end
            8'h2E: begin plain = 8'h35; shifted = 8'h25; end
            8'h36: begin plain = 8'h36; shifted = 8'h5E; end
            8'h3D: begin plain = 8'h37; shifted = 8'h26; end
            8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
            8'h46: begin plain = 8'h39; shifted = 8'h28; end
            8'h0E: begin plain = 8'h60; shifted = 8'h7E; end
            8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end
            8'h55: begin plain = 8'h3D; shifted = 8'h2B; end
            8'h54: begin plain = 8'h5B; shifted = 8'h7B; end
            8'h5B: begin plain = 8'h5D; shifted = 8'h7D; end
            8'h5D: begin plain = 8'h5C; shifted = 8'h7C; end
            8'h4C: begin plain = 8'h3B; shifted = 8'h3A; end
            8'h52: begin plain = 8'h27; shifted = 8'h22; end
            8'h41: begin plain = 8'h2C; shifted = 8'h3C; end
            8'h49: begin plain = 8'h2E; shifted = 8'h3E; end
            8'h4A: begin plain = 8'h2F; shifted = 8'h3F; end
            SC_SPACE: begin plain = 8'h20; shifted = 8'h20; end
            SC_ENTER: begin plain = 8'h0D; shifted = 8'h0D; end
            SC_BKSP:  begin plain = 8'h08; shifted = 8'h08; end
            default: ;
        endcase
    end

    // Caps-lock only affects letters; shift XOR caps selects uppercase.
    always_comb begin
        ascii = ASCII_NONE;
        if (letter != ASCII_NONE) begin
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            ascii = shift ? shifted : plain;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, modifier tracking and ASCII FIFO.
// Define KEY_REPEAT_FILTER_EN to drop typematic repeats of the last pushed key.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             read_data,
    input  logic             err,
    output logic [7:0]       ascii_out,
    output logic             ascii_valid,
    input  logic             ascii_ready,
    output logic             shift_held,
    output logic             caps_lock,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    input  logic             clear_overflow,
    output ps2_state_e       dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Handshake: a character transfers on every cycle where ascii_valid and
    // ascii_ready are both high; ascii_out holds the head until that happens.

    ps2_state_e       state_q, state_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic             caps_q, caps_d;
    logic [7:0]       head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic [7:0]       map_ascii;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             ovf_set;
    logic [PTR_W-1:0] rd_next;

`ifdef KEY_REPEAT_FILTER_EN
    logic [7:0]       last_make_q, last_make_d;
`endif

    ps2_ascii_map u_map (
        .scancode (rx_data),
        .shift    (lshift_q | rshift_q),
        .caps     (caps_q),
        .ascii    (map_ascii)
    );

    always_comb begin
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        push_req = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
        last_make_d = last_make_q;
`endif
        if (read_data && err) begin
            state_d = IDLE;
        end else if (read_data) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = BREAK;
                    end else if (rx_data == SC_EXT) begin
                        state_d = EXT;
                    end else if (rx_data == SC_LSHIFT) begin
                        lshift_d = 1'b1;
                    end else if (rx_data == SC_RSHIFT) begin
                        rshift_d = 1'b1;
                    end else if (rx_data == SC_CAPS) begin
                        caps_d = ~caps_q;
                    end else if (map_ascii != ASCII_NONE) begin
`ifdef KEY_REPEAT_FILTER_EN
                        if (rx_data != last_make_q) begin
                            push_req    = 1'b1;
                            last_make_d = rx_data;
                        end
`else
                        push_req = 1'b1;
`endif
                    end
                end
                BREAK: begin
                    if (rx_data == SC_LSHIFT) lshift_d = 1'b0;
                    if (rx_data == SC_RSHIFT) rshift_d = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
                    if (rx_data == last_make_q) last_make_d = ASCII_NONE;
`endif
                    state_d = IDLE;
                end
                // Extended keys (arrows, fake shifts) never produce characters.
                EXT: begin
                    state_d = (rx_data == SC_BREAK) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
`ifdef KEY_REPEAT_FILTER_EN
                    if (rx_data == last_make_q) last_make_d = ASCII_NONE;
`endif
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && ascii_ready;
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;
    assign rd_next = rd_ptr_q + PTR_W'(1);

    // The head register tracks the entry at rd_ptr, including a write that
    // lands in an empty FIFO or refills it as the last entry leaves.
    always_comb begin
        wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_next : rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;
        overflow_d = clear_overflow ? 1'b0 : (overflow_q | ovf_set);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (pop) begin
            if (count_q > CNT_W'(1)) begin
                head_d = mem_q[rd_next];
            end else if (push) begin
                head_d = map_ascii;
            end else begin
                head_d = ASCII_NONE;
            end
        end else if (push && (count_q == '0)) begin
            head_d = map_ascii;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            caps_q     <= 1'b0;
            head_q     <= ASCII_NONE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            caps_q     <= caps_d;
            head_q     <= head_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_make_q <= ASCII_NONE;
        end else begin
            last_make_q <= last_make_d;
        end
    end
`endif

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= map_ascii;
        end
    end

    assign ascii_out   = head_q;
    assign ascii_valid = (count_q != '0);
    assign shift_held  = lshift_q | rshift_q;
    assign caps_lock   = caps_q;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule
